// File: rtl/line_wb_serializer_pkg.sv
// Shared types and sizing helpers for the line write-back serializer.
package wb_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  // Width in bits of one cache line.
  function automatic int line_w(input int offset_len);
    return 1 << (offset_len + 3);
  endfunction

  // Number of segment-wide beats in a full line.
  function automatic int beats(input int offset_len, input int segment_width);
    return line_w(offset_len) / segment_width;
  endfunction

  // Index width, never narrower than one bit.
  function automatic int idx_w(input int offset_len, input int segment_width);
    int b;
    b = beats(offset_len, segment_width);
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/line_wb_serializer_if.sv
// Line request and beat output channel bundle.
interface line_wb_serializer_if
  import wb_pkg::*;
#(
  parameter int Offset_len    = 6,
  parameter int Segment_width = 32
);
  localparam int LINE_W = line_w(Offset_len);
  localparam int IDX_W  = idx_w(Offset_len, Segment_width);

  logic                     in_valid;
  logic                     in_ready;
  logic [LINE_W-1:0]        in_line;
  logic [IDX_W-1:0]         in_start;
  logic [IDX_W-1:0]         in_len;
  logic                     out_valid;
  logic                     out_ready;
  logic [Segment_width-1:0] out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     done;

  modport slave (
    input  in_valid, in_line, in_start, in_len, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, done
  );

  modport master (
    output in_valid, in_line, in_start, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, done
  );
endinterface

// File: rtl/line_wb_serializer_seg_sel.sv
// Combinational selection of one segment out of a line.
module line_seg_sel #(
  parameter int LINE_W        = 512,
  parameter int Segment_width = 32,
  parameter int IDX_W         = 4
) (
  input  logic [LINE_W-1:0]        line,
  input  logic [IDX_W-1:0]         idx,
  output logic [Segment_width-1:0] seg
);

  // Indexed part-select scales to any line/segment geometry.
  always_comb begin
    seg = line[int'(idx) * Segment_width +: Segment_width];
  end

endmodule

// File: rtl/line_wb_serializer.sv
// Captures a cache line and streams a wrap-around run of its segments as beats.
module line_wb_serializer
  import wb_pkg::*;
#(
  parameter int Offset_len    = 6,
  parameter int Segment_width = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  line_wb_serializer_if.slave  bus
);

  localparam int LINE_W = line_w(Offset_len);
  localparam int BEATS  = beats(Offset_len, Segment_width);
  localparam int IDX_W  = idx_w(Offset_len, Segment_width);

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   remain_q, remain_d;
  logic               done_q, done_d;

  // Next-state: accept a line in IDLE, advance one segment per handshake in BUSY.
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          line_d   = bus.in_line;
          ptr_d    = bus.in_start;
          remain_d = bus.in_len;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (remain_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d    = ptr_q + 1'b1;
            remain_d = remain_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (BEATS == 1) begin
      ptr_d    = '0;
      remain_d = '0;
    end
  end

  // State, line buffer, counters and done flop; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      line_q   <= '0;
      ptr_q    <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  line_seg_sel #(
    .LINE_W        (LINE_W),
    .Segment_width (Segment_width),
    .IDX_W         (IDX_W)
  ) u_seg_sel (
    .line (line_q),
    .idx  (ptr_q),
    .seg  (bus.out_data)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == BUSY);
  assign bus.out_last  = (state_q == BUSY) && (remain_q == '0);
  assign bus.out_idx   = ptr_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_line_wb_serializer.sv
// Scoreboard bench for line_wb_serializer: default geometry plus a 4-beat 64-bit variant.
module tb_line_wb_serializer;
  import wb_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  line_wb_serializer_if #(.Offset_len(6), .Segment_width(32)) bus ();
  line_wb_serializer_if #(.Offset_len(5), .Segment_width(64)) bus2 ();

  line_wb_serializer #(.Offset_len(6), .Segment_width(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  line_wb_serializer #(.Offset_len(5), .Segment_width(64)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  beat_t exp_q[$];
  beat_t exp2_q[$];
  int    total = 0;
  int    bad = 0;
  int    beats_seen = 0;
  logic  done_exp = 1'b0;
  logic  stall_prev = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_idx;
  logic        held_last;
  logic  bp_mode = 1'b0;
  int    bp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor for the default instance: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
      done_exp   = 1'b0;
    end else begin
      if (bus.done || done_exp) check("done_pulse", 64'(bus.done), 64'(done_exp));
      done_exp = 1'b0;
      if (stall_prev && bus.out_valid) begin
        check("stall_data", 64'(bus.out_data), 64'(held_data));
        check("stall_idx", 64'(bus.out_idx), 64'(held_idx));
        check("stall_last", 64'(bus.out_last), 64'(held_last));
      end
      if (bus.out_valid) check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      stall_prev = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_idx   = bus.out_idx;
      held_last  = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        beat_t e;
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.out_data), e.data);
          check("beat_idx", 64'(bus.out_idx), 64'(e.idx));
          check("beat_last", 64'(bus.out_last), 64'(e.last));
          done_exp = e.last;
        end
      end
    end
  end

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    if (rstn && bus2.out_valid && bus2.out_ready) begin
      beat_t e;
      if (exp2_q.size() == 0) begin
        check("unexpected_beat2", 64'd1, 64'd0);
      end else begin
        e = exp2_q.pop_front();
        check("beat2_data", bus2.out_data, e.data);
        check("beat2_idx", 64'(bus2.out_idx), 64'(e.idx));
        check("beat2_last", 64'(bus2.out_last), 64'(e.last));
      end
    end
  end

  // out_ready driver: constant 1, or the 0,0,1,0,1 stall pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.out_ready = (bp_cnt % 5 == 2) || (bp_cnt % 5 == 4);
        bp_cnt++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic [511:0] line, input int start, input int len, input bit full_rate);
    int n;
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    for (int j = 0; j <= len; j++) begin
      beat_t e;
      e.idx  = 4'((start + j) % 16);
      e.data = {32'h0, line[int'(e.idx) * 32 +: 32]};
      e.last = (j == len);
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.in_line  = line;
    bus.in_start = 4'(start);
    bus.in_len   = 4'(len);
    @(posedge clk);
    #1;
    bus.in_line  = ~line;
    bus.in_start = 4'(start + 5);
    bus.in_len   = 4'(len + 3);
    n = 0;
    if (len >= 2) begin
      @(posedge clk);
      #1;
      n = 1;
    end
    bus.in_valid = 1'b0;
    while (!bus.done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) check("done_timeout", 64'd0, 64'd1);
    else if (full_rate) check("burst_cycles", 64'(n), 64'(len + 1));
    check("in_ready_at_done", 64'(bus.in_ready), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [511:0] line0;
    logic [511:0] line2;
    logic [255:0] line64;
    int base;
    int w;
    int n;

    bus.in_valid   = 1'b0;
    bus.in_line    = '0;
    bus.in_start   = '0;
    bus.in_len     = '0;
    bus.out_ready  = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_line   = '0;
    bus2.in_start  = '0;
    bus2.in_len    = '0;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      line0[i*32 +: 32] = 32'(i);
      line2[i*32 +: 32] = 32'hBEEF_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      line64[i*64 +: 64] = {32'hC0DE_0000 + 32'(i), 32'h1234_5670 + 32'(i)};
    end

    #3;
    checkOutput("reset");
    check("reset_out_idx", 64'(bus.out_idx), 64'd0);
    check("reset_out_data", 64'(bus.out_data), 64'd0);
    check("reset2_out_data", bus2.out_data, 64'd0);
    check("reset2_in_ready", 64'(bus2.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("[TB] full line, start 0");
    applyStimulus(line0, 0, 15, 1'b1);
    $display("[TB] wrap, start 13 len 4");
    applyStimulus(line0, 13, 4, 1'b1);
    $display("[TB] single beat, start 7");
    applyStimulus(line0, 7, 0, 1'b1);

    $display("[TB] backpressure");
    bp_mode = 1'b1;
    applyStimulus(line2, 2, 9, 1'b0);
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset mid-burst");
    base = beats_seen;
    for (int j = 0; j < 16; j++) begin
      beat_t e;
      e.idx  = 4'(j);
      e.data = {32'h0, line0[j*32 +: 32]};
      e.last = (j == 15);
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.in_line  = line0;
    bus.in_start = 4'd0;
    bus.in_len   = 4'd15;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (beats_seen < base + 5 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("beats_before_reset", 64'(beats_seen - base), 64'd5);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("released");
    @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(bus.done), 64'd0);
    applyStimulus(line2, 9, 2, 1'b1);

    $display("[TB] 64-bit segments, 4 beats");
    for (int j = 0; j < 4; j++) begin
      beat_t e;
      e.idx  = 4'((3 + j) % 4);
      e.data = line64[int'(e.idx) * 64 +: 64];
      e.last = (j == 3);
      exp2_q.push_back(e);
    end
    bus2.in_valid = 1'b1;
    bus2.in_line  = line64;
    bus2.in_start = 2'd3;
    bus2.in_len   = 2'd3;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    bus2.in_line  = '0;
    n = 0;
    while (!bus2.done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("burst2_cycles", 64'(n), 64'd4);
    check("queue2_drained", 64'(exp2_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(bus.in_ready), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
